uart_rx_cfg: RTL and testbench
==============================

UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL have parameter CLK_RATE, default 50000000, meaning input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, meaning line bit rate; CLKS_PER_BIT = CLK_RATE/BAUD using integer division.
REQ-003 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame; legal values are 5..9.
REQ-004 SHALL have parameter PARITY, default 0, meaning 0 = none, 1 = odd, 2 = even.
REQ-005 SHALL have parameter STOP_BITS, default 1, meaning stop bits checked per frame; legal values are 1 or 2.
REQ-006 SHALL have port i_Clock, input, 1 bit, the single clock; all logic on its rising edge.
REQ-007 SHALL have port i_Reset, input, 1 bit, asynchronous active-high reset.
REQ-008 SHALL have port i_Rx_Serial, input, 1 bit, asynchronous serial line, idle high.
REQ-009 SHALL have port o_Rx_DV, output, 1 bit, one-cycle frame-complete strobe.
REQ-010 SHALL have port o_Rx_Byte, output, DATA_BITS bits, received data, LSB received first.
REQ-011 SHALL have port o_Parity_Err, output, 1 bit, parity mismatch for the frame being strobed.
REQ-012 SHALL have port o_Frame_Err, output, 1 bit, a stop bit sampled low for the frame being strobed.
REQ-013 SHALL have port o_Break, output, 1 bit, break condition for the frame being strobed.
REQ-014 SHALL have port o_Busy, output, 1 bit, high in every state other than IDLE.

Function
REQ-015 SHALL synchronise i_Rx_Serial through two flops; all sampling uses the second flop output (rx_s).
REQ-016 SHALL use a bit-timing counter of width $clog2(CLKS_PER_BIT); the counter never exceeds CLKS_PER_BIT-1.
REQ-017 SHALL implement states WAIT_IDLE, IDLE, START, DATA, PARITY, STOP.
REQ-018 WAIT_IDLE: count consecutive cycles with rx_s=1; on reaching CLKS_PER_BIT-1, go to IDLE; any rx_s=0 clears the count.
REQ-019 IDLE: on rx_s=0, clear the counter and go to START.
REQ-020 START: at count (CLKS_PER_BIT-1)/2, go to DATA if rx_s=0, else go to IDLE with no strobe (glitch reject).
REQ-021 DATA: sample rx_s every CLKS_PER_BIT cycles after the start midpoint into bit index 0..DATA_BITS-1; after the last bit, go to PARITY if PARITY!=0, else to STOP.
REQ-022 PARITY: sample one bit CLKS_PER_BIT cycles later; error when data XOR parity bit is 0 (odd mode) or 1 (even mode).
REQ-023 STOP: sample STOP_BITS bits, each at CLKS_PER_BIT spacing; any low sample sets the frame error.
REQ-024 SHALL assert o_Rx_DV for exactly one cycle, in the cycle after the final stop sample.
REQ-025 SHALL update o_Rx_Byte and the three error flags in that same cycle; all four hold until the next strobe.
REQ-026 After the strobe, the state SHALL go to IDLE, except after a break, when it goes to WAIT_IDLE.
REQ-027 Break SHALL be flagged when all data bits, the parity bit (if present) and the first stop bit are 0.
REQ-028 A break SHALL also set o_Frame_Err.
REQ-029 SHALL update o_Rx_Byte only on a strobe; frames rejected by the glitch check SHALL leave all outputs unchanged.
REQ-030 A low on rx_s in the cycle after the strobe SHALL be accepted as the next start bit, so back-to-back frames incur no dead time.

Reset
REQ-031 i_Reset high SHALL immediately force o_Rx_DV=0, o_Rx_Byte=0, all error flags=0, o_Busy=1 and state=WAIT_IDLE.
REQ-032 i_Reset high SHALL set both synchroniser flops to 1 and clear the counter and bit index.
REQ-033 Reset asserted mid-frame SHALL abort the frame with no strobe.
REQ-034 After reset release, the block SHALL ignore the line until one full idle bit time is seen (WAIT_IDLE), so no partial byte is decoded.

Verification (CLK_RATE=1000, BAUD=100, so CLKS_PER_BIT=10)
REQ-035 Defaults DATA_BITS=8, PARITY=0, line idle high after reset, send 0xA5 -> exactly one o_Rx_DV pulse, o_Rx_Byte=0xA5, all flags 0, o_Busy low 1 cycle later.
REQ-036 PARITY=2, send 0x03 with parity bit 1 -> o_Parity_Err=1 and o_Rx_Byte=0x03; repeat with parity bit 0 -> o_Parity_Err=0.
REQ-037 STOP_BITS=2, second stop bit driven low -> o_Frame_Err=1 and o_Break=0; next frame 0x5A sent immediately -> o_Rx_DV with o_Rx_Byte=0x5A and flags 0.
REQ-038 Line held low for 15 bit times -> one strobe with o_Rx_Byte=0, o_Break=1, o_Frame_Err=1; no further strobe until the line returns high for 10 cycles and a new frame arrives.
REQ-039 4-cycle low glitch on an idle line -> no o_Rx_DV, o_Rx_Byte unchanged, o_Busy low again by cycle 7.
REQ-040 i_Reset pulsed during bit 3 of a frame, line left toggling the rest of the frame -> no strobe for that frame; the following clean frame 0x3C decodes correctly.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: synchronised line, mid-bit sampling, optional parity,
// one or two stop bits, break detection and a one-cycle frame strobe with sticky status.
module uart_rx_cfg #(
    parameter int CLK_RATE  = 50000000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_Rx_Serial,
    output logic                 o_Rx_DV,
    output logic [DATA_BITS-1:0] o_Rx_Byte,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Break,
    output logic                 o_Busy
);

    localparam int CLKS_PER_BIT = CLK_RATE / BAUD;
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_MID   = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_WAIT_IDLE = 3'd0,
        ST_IDLE      = 3'd1,
        ST_START     = 3'd2,
        ST_DATA      = 3'd3,
        ST_PARITY    = 3'd4,
        ST_STOP      = 3'd5
    } state_t;

    function automatic logic parity_error(input logic [DATA_BITS-1:0] data, input logic pbit);
        logic err;
        case (PARITY)
            32'sd1:  err = ~(^data ^ pbit);
            32'sd2:  err = ^data ^ pbit;
            default: err = 1'b0;
        endcase
        return err;
    endfunction

    logic                 rx_meta_q, rx_sync_q, rx_s;
    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_bit_q, par_bit_d;
    logic                 stop1_low_q, stop1_low_d;
    logic                 stop_err_q, stop_err_d;
    logic                 dv_q, dv_d;
    logic [DATA_BITS-1:0] byte_q, byte_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 brk_q, brk_d;
    logic                 busy_q, busy_d;

    logic frame_end_s, first_stop_low_s, frame_brk_s, frame_ferr_s;

    assign rx_s = rx_sync_q;

    // Frame verdict, valid in the cycle the final stop bit is sampled
    assign frame_end_s      = (state_q == ST_STOP) && (cnt_q == CNT_LAST) && (idx_q == STOP_LAST);
    assign first_stop_low_s = (idx_q == IW'(0)) ? ~rx_s : stop1_low_q;
    assign frame_brk_s      = (shift_q == '0) && ((PARITY == 0) || !par_bit_q) && first_stop_low_s;
    assign frame_ferr_s     = stop_err_q | ~rx_s | frame_brk_s;

    // State, datapath and output registers
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            state_q     <= ST_WAIT_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            par_bit_q   <= 1'b0;
            stop1_low_q <= 1'b0;
            stop_err_q  <= 1'b0;
            dv_q        <= 1'b0;
            byte_q      <= '0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            brk_q       <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            rx_meta_q   <= i_Rx_Serial;
            rx_sync_q   <= rx_meta_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            par_bit_q   <= par_bit_d;
            stop1_low_q <= stop1_low_d;
            stop_err_q  <= stop_err_d;
            dv_q        <= dv_d;
            byte_q      <= byte_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            brk_q       <= brk_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state and bit-timing logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        par_bit_d   = par_bit_q;
        stop1_low_d = stop1_low_q;
        stop_err_d  = stop_err_q;
        case (state_q)
            ST_WAIT_IDLE: begin
                if (!rx_s) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_q == CNT_MID) begin
                    cnt_d       = '0;
                    idx_d       = '0;
                    par_bit_d   = 1'b0;
                    stop1_low_d = 1'b0;
                    stop_err_d  = 1'b0;
                    state_d     = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    if (idx_q == DATA_LAST) begin
                        idx_d   = '0;
                        state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    par_bit_d = rx_s;
                    state_d   = ST_STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d       = '0;
                    stop_err_d  = stop_err_q | ~rx_s;
                    stop1_low_d = first_stop_low_s;
                    if (idx_q == STOP_LAST) begin
                        idx_d   = '0;
                        state_d = frame_brk_s ? ST_WAIT_IDLE : ST_IDLE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_WAIT_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // Strobe and status capture; status holds until the next completed frame
    always_comb begin
        dv_d   = 1'b0;
        byte_d = byte_q;
        perr_d = perr_q;
        ferr_d = ferr_q;
        brk_d  = brk_q;
        busy_d = (state_d != ST_IDLE);
        if (frame_end_s) begin
            dv_d   = 1'b1;
            byte_d = shift_q;
            perr_d = parity_error(shift_q, par_bit_q);
            ferr_d = frame_ferr_s;
            brk_d  = frame_brk_s;
        end else begin
            dv_d = 1'b0;
        end
    end

    assign o_Rx_DV      = dv_q;
    assign o_Rx_Byte    = byte_q;
    assign o_Parity_Err = perr_q;
    assign o_Frame_Err  = ferr_q;
    assign o_Break      = brk_q;
    assign o_Busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three configurations (plain 8N1, even parity, two stop bits)
// fed from bench-built frames; a scoreboard matches every strobe against queued expectations.
module tb_uart_rx_cfg;

    logic clk = 1'b0;
    logic rst;
    logic rx_a, rx_b, rx_c;
    logic dv_a, dv_b, dv_c;
    logic [7:0] byte_a, byte_b, byte_c;
    logic perr_a, perr_b, perr_c;
    logic ferr_a, ferr_b, ferr_c;
    logic brk_a, brk_b, brk_c;
    logic busy_a, busy_b, busy_c;

    logic [2:0]  dv_v;
    logic [2:0]  busy_v;
    logic [10:0] res_v [3];

    // expected entry layout: {break, frame_err, parity_err, data}
    logic [10:0] q_a[$];
    logic [10:0] q_b[$];
    logic [10:0] q_c[$];
    logic [7:0]  last_a;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_rx_cfg #(.CLK_RATE(1000), .BAUD(100)) dut_a (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx_a), .o_Rx_DV(dv_a), .o_Rx_Byte(byte_a),
        .o_Parity_Err(perr_a), .o_Frame_Err(ferr_a), .o_Break(brk_a), .o_Busy(busy_a));

    uart_rx_cfg #(.CLK_RATE(1000), .BAUD(100), .PARITY(2)) dut_b (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx_b), .o_Rx_DV(dv_b), .o_Rx_Byte(byte_b),
        .o_Parity_Err(perr_b), .o_Frame_Err(ferr_b), .o_Break(brk_b), .o_Busy(busy_b));

    uart_rx_cfg #(.CLK_RATE(1000), .BAUD(100), .STOP_BITS(2)) dut_c (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx_c), .o_Rx_DV(dv_c), .o_Rx_Byte(byte_c),
        .o_Parity_Err(perr_c), .o_Frame_Err(ferr_c), .o_Break(brk_c), .o_Busy(busy_c));

    assign dv_v     = {dv_c, dv_b, dv_a};
    assign busy_v   = {busy_c, busy_b, busy_a};
    assign res_v[0] = {brk_a, ferr_a, perr_a, byte_a};
    assign res_v[1] = {brk_b, ferr_b, perr_b, byte_b};
    assign res_v[2] = {brk_c, ferr_c, perr_c, byte_c};

    task automatic set_line(input int which, input logic v);
        case (which)
            0:       rx_a = v;
            1:       rx_b = v;
            default: rx_c = v;
        endcase
    endtask

    task automatic hold(input int which, input logic v, input int n);
        set_line(which, v);
        repeat (n) @(negedge clk);
    endtask

    // Builds one frame for the given receiver, queues its expected result, then drives it
    task automatic send_frame(input int which, input logic [7:0] data, input logic pbit,
                              input logic stop1, input logic stop2);
        logic has_par, two_stop, brk, ferr, perr;
        has_par  = (which == 1);
        two_stop = (which == 2);
        brk  = (data == 8'h00) && (!has_par || !pbit) && !stop1;
        ferr = !stop1 || (two_stop && !stop2) || brk;
        perr = has_par ? ((^data) ^ pbit) : 1'b0;
        case (which)
            0:       begin q_a.push_back({brk, ferr, perr, data}); last_a = data; end
            1:       q_b.push_back({brk, ferr, perr, data});
            default: q_c.push_back({brk, ferr, perr, data});
        endcase
        hold(which, 1'b0, 10);
        for (int i = 0; i < 8; i++) hold(which, data[i], 10);
        if (has_par) hold(which, pbit, 10);
        hold(which, stop1, 10);
        if (two_stop) hold(which, stop2, 10);
    endtask

    task automatic check_drained(input string name, input int qsize);
        checks++;
        if (qsize !== 0) begin
            errors++;
            $display("FAIL %s pending_strobes got=%0d required=0", name, qsize);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rx_a = 1'b1; rx_b = 1'b1; rx_c = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({dv_v[k], res_v[k], busy_v[k]} !== {1'b0, 11'h000, 1'b1}) begin
                errors++;
                $display("FAIL reset_state dut=%0d got=%h required=%h", k,
                         {dv_v[k], res_v[k], busy_v[k]}, {1'b0, 11'h000, 1'b1});
            end
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (busy_v !== 3'b111) begin
            errors++;
            $display("FAIL wait_idle_busy got=%b required=111", busy_v);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (busy_v !== 3'b000) begin
            errors++;
            $display("FAIL idle_after_reset got=%b required=000", busy_v);
        end
    endtask

    task automatic test_basic;
        send_frame(0, 8'hA5, 1'b0, 1'b1, 1'b1);
        hold(0, 1'b1, 2);
        checks++;
        if ({busy_a, byte_a} !== {1'b0, 8'hA5}) begin
            errors++;
            $display("FAIL basic_after got=%h required=%h", {busy_a, byte_a}, {1'b0, 8'hA5});
        end
        check_drained("basic_a5", q_a.size());
        send_frame(0, 8'h00, 1'b0, 1'b1, 1'b1);
        send_frame(0, 8'hFF, 1'b0, 1'b1, 1'b1);
        hold(0, 1'b1, 20);
        checks++;
        if (byte_a !== last_a) begin
            errors++;
            $display("FAIL byte_hold got=%h required=%h", byte_a, last_a);
        end
        check_drained("basic_back_to_back", q_a.size());
    endtask

    task automatic test_parity;
        send_frame(1, 8'h03, 1'b1, 1'b1, 1'b1);
        hold(1, 1'b1, 10);
        send_frame(1, 8'h03, 1'b0, 1'b1, 1'b1);
        hold(1, 1'b1, 10);
        send_frame(1, 8'h81, 1'b1, 1'b1, 1'b1);
        hold(1, 1'b1, 10);
        check_drained("parity", q_b.size());
    endtask

    task automatic test_back_to_back;
        send_frame(2, 8'h66, 1'b0, 1'b1, 1'b0);
        send_frame(2, 8'h5A, 1'b0, 1'b1, 1'b1);
        hold(2, 1'b1, 10);
        check_drained("stop2_back_to_back", q_c.size());
    endtask

    task automatic test_glitch;
        hold(0, 1'b0, 4);
        checks++;
        if (busy_a !== 1'b1) begin
            errors++;
            $display("FAIL glitch_seen got=%b required=1", busy_a);
        end
        hold(0, 1'b1, 6);
        checks++;
        if ({busy_a, byte_a} !== {1'b0, last_a}) begin
            errors++;
            $display("FAIL glitch_reject got=%h required=%h", {busy_a, byte_a}, {1'b0, last_a});
        end
        check_drained("glitch", q_a.size());
    endtask

    task automatic test_break;
        q_a.push_back({1'b1, 1'b1, 1'b0, 8'h00});
        last_a = 8'h00;
        hold(0, 1'b0, 150);
        checks++;
        if (busy_a !== 1'b1) begin
            errors++;
            $display("FAIL break_busy got=%b required=1", busy_a);
        end
        hold(0, 1'b1, 5);
        checks++;
        if (busy_a !== 1'b1) begin
            errors++;
            $display("FAIL break_wait_idle got=%b required=1", busy_a);
        end
        hold(0, 1'b1, 15);
        check_drained("break", q_a.size());
        send_frame(0, 8'hC3, 1'b0, 1'b1, 1'b1);
        hold(0, 1'b1, 10);
        check_drained("after_break", q_a.size());
    endtask

    task automatic test_reset_midframe;
        logic [7:0] aborted;
        aborted = 8'h0A;
        hold(0, 1'b0, 10);
        for (int i = 0; i < 3; i++) hold(0, aborted[i], 10);
        hold(0, aborted[3], 5);
        rst = 1'b1;
        #1;
        checks++;
        if ({dv_a, byte_a, busy_a} !== {1'b0, 8'h00, 1'b1}) begin
            errors++;
            $display("FAIL reset_async got=%h required=%h", {dv_a, byte_a, busy_a}, {1'b0, 8'h00, 1'b1});
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 4; i < 8; i++) hold(0, aborted[i], 10);
        hold(0, 1'b1, 30);
        checks++;
        if (byte_a !== 8'h00) begin
            errors++;
            $display("FAIL aborted_frame got=%h required=00", byte_a);
        end
        send_frame(0, 8'h3C, 1'b0, 1'b1, 1'b1);
        hold(0, 1'b1, 10);
        check_drained("after_reset_frame", q_a.size());
        checks++;
        if (byte_a !== 8'h3C) begin
            errors++;
            $display("FAIL recovered_byte got=%h required=3c", byte_a);
        end
    endtask

    initial begin
        rst = 1'b1;
        rx_a = 1'b1; rx_b = 1'b1; rx_c = 1'b1;
        last_a = 8'h00;
        fork
            begin : monitor
                logic [10:0] exp_v;
                int qn;
                forever begin
                    @(negedge clk);
                    for (int k = 0; k < 3; k++) begin
                        if (dv_v[k] === 1'b1) begin
                            exp_v = 11'h000;
                            qn = 0;
                            case (k)
                                0:       begin qn = q_a.size(); if (qn > 0) exp_v = q_a.pop_front(); end
                                1:       begin qn = q_b.size(); if (qn > 0) exp_v = q_b.pop_front(); end
                                default: begin qn = q_c.size(); if (qn > 0) exp_v = q_c.pop_front(); end
                            endcase
                            checks++;
                            if (qn == 0) begin
                                errors++;
                                $display("FAIL unexpected_strobe dut=%0d got=%h required=none", k, res_v[k]);
                            end else begin
                                if (res_v[k] !== exp_v) begin
                                    errors++;
                                    $display("FAIL strobe_data dut=%0d got=%h required=%h", k, res_v[k], exp_v);
                                end
                                checks++;
                                if (busy_v[k] !== exp_v[10]) begin
                                    errors++;
                                    $display("FAIL strobe_busy dut=%0d got=%b required=%b", k, busy_v[k], exp_v[10]);
                                end
                            end
                        end
                    end
                end
            end
        join_none
        test_reset();
        test_basic();
        test_parity();
        test_back_to_back();
        test_glitch();
        test_break();
        test_reset_midframe();
        repeat (20) @(negedge clk);
        check_drained("final_a", q_a.size());
        check_drained("final_b", q_b.size());
        check_drained("final_c", q_c.size());
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
